// File: rtl/pll_clk_manager.sv
// Clock/reset manager behind the PLL: qualifies lock, releases per-channel resets in stages,
// and generates phase-accumulator clock enables. Define PLL_TIMEOUT_EN to build the lock watchdog.
module pll_clk_manager #(
  parameter int NUM_CH      = 2,
  parameter int ACC_W       = 16,
  parameter int STABLE_CYC  = 1024,
  parameter int STAGE_GAP   = 16,
  parameter int LOSS_CNT_W  = 8,
  parameter int TIMEOUT_CYC = 65536
) (
  input  logic                    clkin,
  input  logic                    rst_n,
  input  logic                    pll_lock,
  input  logic [NUM_CH*ACC_W-1:0] ch_inc,
  input  logic [NUM_CH-1:0]       ch_en_req,
  output logic [NUM_CH-1:0]       ch_ce,
  output logic [NUM_CH-1:0]       ch_rst_n,
  output logic                    all_ready,
  output logic [LOSS_CNT_W-1:0]   lock_loss_cnt,
  output logic                    pll_reset
);

  typedef enum logic [2:0] {
    WAIT_LOCK,
    STABLE,
    RELEASE,
    RUN,
    PLL_RST
  } state_t;

  localparam int REL_END = STAGE_GAP * NUM_CH;
  localparam int CNT_MAX = (STABLE_CYC > REL_END) ? STABLE_CYC : REL_END;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  state_t             state, state_next;
  logic [CNT_W-1:0]   cnt, cnt_next;
  logic [NUM_CH-1:0]  rst_next;
  logic               loss_inc;
  logic               timeout;
  logic               pulse_done;
  logic               lk_meta, lk;

  // NOTE: sequential state always uses non-blocking assignments so every flop
  // samples the pre-edge value of every other flop, independent of statement order.
  always_ff @(posedge clkin or negedge rst_n) begin
    if (!rst_n) begin
      lk_meta <= 1'b0;
      lk      <= 1'b0;
    end else begin
      lk_meta <= pll_lock;
      lk      <= lk_meta;
    end
  end

`ifdef PLL_TIMEOUT_EN
  localparam int TMR_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  logic [TMR_W-1:0] tmr;
  logic [2:0]       pulse_cnt;
  logic             watch;

  // The watchdog only runs while still waiting for a usable lock.
  assign watch      = (state == WAIT_LOCK) || (state == STABLE);
  assign timeout    = watch && (tmr == TMR_W'(TIMEOUT_CYC - 1));
  assign pulse_done = (state == PLL_RST) && (pulse_cnt == 3'd7);

  always_ff @(posedge clkin or negedge rst_n) begin
    if (!rst_n) begin
      tmr       <= '0;
      pulse_cnt <= '0;
      pll_reset <= 1'b0;
    end else begin
      tmr       <= (watch && !timeout) ? tmr + TMR_W'(1) : '0;
      pulse_cnt <= (state == PLL_RST) ? pulse_cnt + 3'd1 : 3'd0;
      pll_reset <= (state_next == PLL_RST);
    end
  end
`else
  // The timeout length is only meaningful when the watchdog is built in.
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYC;
  assign timeout        = 1'b0;
  assign pulse_done     = 1'b0;
  assign pll_reset      = 1'b0;
`endif

  // NOTE: every signal written here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    rst_next   = ch_rst_n;
    loss_inc   = 1'b0;
    if (timeout) begin
      state_next = PLL_RST;
      cnt_next   = '0;
    end else begin
      case (state)
        WAIT_LOCK: begin
          if (lk) begin
            state_next = STABLE;
            cnt_next   = '0;
          end
        end
        STABLE: begin
          if (!lk) begin
            state_next = WAIT_LOCK;
          end else if (cnt == CNT_W'(STABLE_CYC - 1)) begin
            state_next = RELEASE;
            cnt_next   = '0;
          end else begin
            cnt_next = cnt + CNT_W'(1);
          end
        end
        RELEASE: begin
          if (!lk) begin
            state_next = WAIT_LOCK;
            rst_next   = '0;
            loss_inc   = 1'b1;
          end else if (ch_rst_n[NUM_CH-1]) begin
            state_next = RUN;
          end else begin
            cnt_next = cnt + CNT_W'(1);
            for (int i = 0; i < NUM_CH; i++) begin
              if (cnt_next >= CNT_W'(STAGE_GAP * (i + 1))) rst_next[i] = 1'b1;
            end
          end
        end
        RUN: begin
          if (!lk) begin
            state_next = WAIT_LOCK;
            rst_next   = '0;
            loss_inc   = 1'b1;
          end
        end
        PLL_RST: begin
          if (pulse_done) state_next = WAIT_LOCK;
        end
        default: state_next = WAIT_LOCK;
      endcase
    end
  end

  always_ff @(posedge clkin or negedge rst_n) begin
    if (!rst_n) begin
      state         <= WAIT_LOCK;
      cnt           <= '0;
      ch_rst_n      <= '0;
      all_ready     <= 1'b0;
      lock_loss_cnt <= '0;
    end else begin
      state     <= state_next;
      cnt       <= cnt_next;
      ch_rst_n  <= rst_next;
      all_ready <= (state_next == RUN);
      if (loss_inc && (lock_loss_cnt != '1)) lock_loss_cnt <= lock_loss_cnt + LOSS_CNT_W'(1);
    end
  end

  logic [ACC_W-1:0] acc [NUM_CH];

  // A channel only advances while its reset is released now and stays released
  // this edge, so a lock drop clears phase and enable in the same cycle.
  // NOTE: the accumulator array is explicitly reset so each release starts
  // from phase zero and the first enable lands at a deterministic cycle.
  always_ff @(posedge clkin or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CH; i++) acc[i] <= '0;
      ch_ce <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (!(ch_rst_n[i] && rst_next[i])) begin
          acc[i]   <= '0;
          ch_ce[i] <= 1'b0;
        end else if (ch_en_req[i]) begin
          {ch_ce[i], acc[i]} <= {1'b0, acc[i]} + {1'b0, ch_inc[i*ACC_W +: ACC_W]};
        end else begin
          ch_ce[i] <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_pll_clk_manager.sv
// Scoreboard bench for pll_clk_manager: a lock-run-length reference model pushes expected
// outputs per edge, a monitor pops and compares; directed checks cover the timing rules.
module tb_pll_clk_manager;

  localparam int NUM_CH      = 2;
  localparam int ACC_W       = 8;
  localparam int STABLE_CYC  = 16;
  localparam int STAGE_GAP   = 4;
  localparam int LOSS_CNT_W  = 8;
  localparam int TIMEOUT_CYC = 100;

  logic                    clkin = 1'b0;
  logic                    rst_n;
  logic                    pll_lock;
  logic [NUM_CH*ACC_W-1:0] ch_inc;
  logic [NUM_CH-1:0]       ch_en_req;
  logic [NUM_CH-1:0]       ch_ce;
  logic [NUM_CH-1:0]       ch_rst_n;
  logic                    all_ready;
  logic [LOSS_CNT_W-1:0]   lock_loss_cnt;
  logic                    pll_reset;

  pll_clk_manager #(
    .NUM_CH(NUM_CH), .ACC_W(ACC_W), .STABLE_CYC(STABLE_CYC), .STAGE_GAP(STAGE_GAP),
    .LOSS_CNT_W(LOSS_CNT_W), .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .clkin(clkin), .rst_n(rst_n), .pll_lock(pll_lock), .ch_inc(ch_inc),
    .ch_en_req(ch_en_req), .ch_ce(ch_ce), .ch_rst_n(ch_rst_n), .all_ready(all_ready),
    .lock_loss_cnt(lock_loss_cnt), .pll_reset(pll_reset)
  );

  always #5 clkin = ~clkin;

  typedef struct packed {
    logic [NUM_CH-1:0]     ce;
    logic [NUM_CH-1:0]     rstn;
    logic                  ready;
    logic [LOSS_CNT_W-1:0] loss;
    logic                  prst;
  } obs_t;

  obs_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  bit   sb_on  = 1'b1;

  // Reference model: everything follows from how long the synchronised lock has been
  // continuously high, plus plain modular arithmetic for each phase accumulator.
  bit   lk_hist[2];
  int   run_len = 0;
  int   m_loss  = 0;
  int   m_acc[NUM_CH];

  int   win_left = 0;
  int   pulses[NUM_CH];
  int   sample_n = 0;
  int   last_ce0 = -1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    obs_t e;
    bit   seen;
    int   prev_len;
    int   thr;
    int   sum;
    e = '0;
    if (!rst_n) begin
      lk_hist = '{1'b0, 1'b0};
      run_len = 0;
      m_loss  = 0;
      for (int i = 0; i < NUM_CH; i++) m_acc[i] = 0;
    end else begin
      seen     = lk_hist[1];
      prev_len = run_len;
      run_len  = seen ? ((run_len < 100000) ? run_len + 1 : run_len) : 0;
      if (!seen && prev_len >= 1 + STABLE_CYC && m_loss < 255) m_loss++;
      lk_hist[1] = lk_hist[0];
      lk_hist[0] = pll_lock;
      for (int i = 0; i < NUM_CH; i++) begin
        thr        = 1 + STABLE_CYC + STAGE_GAP * (i + 1);
        e.rstn[i]  = (run_len >= thr);
        if (run_len >= thr + 1 && ch_en_req[i]) begin
          sum      = m_acc[i] + int'(ch_inc[i*ACC_W +: ACC_W]);
          e.ce[i]  = (sum >= 256);
          m_acc[i] = sum % 256;
        end else if (run_len < thr + 1) begin
          m_acc[i] = 0;
        end
      end
      e.ready = (run_len >= 2 + STABLE_CYC + STAGE_GAP * NUM_CH);
      e.loss  = LOSS_CNT_W'(m_loss);
    end
    if (sb_on) exp_q.push_back(e);
  endtask

  task automatic tick();
    model_step();
    @(negedge clkin);
  endtask

  task automatic wait_ready(input int budget);
    int n = 0;
    while (!all_ready && n < budget) begin
      tick();
      n++;
    end
    check("wait_ready", 32'(all_ready), 32'd1);
  endtask

  // Monitor: compares the DUT against the queued expectation one time unit after each edge.
  initial begin
    obs_t e;
    forever begin
      @(posedge clkin);
      #1;
      sample_n++;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("ch_ce", 32'(ch_ce), 32'(e.ce));
        check("ch_rst_n", 32'(ch_rst_n), 32'(e.rstn));
        check("all_ready", 32'(all_ready), 32'(e.ready));
        check("lock_loss_cnt", 32'(lock_loss_cnt), 32'(e.loss));
        check("pll_reset", 32'(pll_reset), 32'(e.prst));
      end
      if (win_left > 0) begin
        win_left--;
        for (int i = 0; i < NUM_CH; i++) pulses[i] += int'(ch_ce[i]);
        if (ch_ce[0]) begin
          if (last_ce0 >= 0) check("ce0_period", 32'(sample_n - last_ce0), 32'd4);
          last_ce0 = sample_n;
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int r0, r1, rdy, r0g;
    rst_n     = 1'b0;
    pll_lock  = 1'b1;
    ch_inc    = '0;
    ch_en_req = '0;
    repeat (5) tick();
    check("reset_rst_n", 32'(ch_rst_n), 32'd0);
    check("reset_ready", 32'(all_ready), 32'd0);
    rst_n = 1'b1;

    // Power-up staged release timing.
    r0 = -1; r1 = -1; rdy = -1;
    for (int n = 1; n <= 60; n++) begin
      tick();
      if (r0 < 0 && ch_rst_n[0]) r0 = n;
      if (r1 < 0 && ch_rst_n[1]) r1 = n;
      if (rdy < 0 && all_ready) rdy = n;
    end
    check("rst0_rise_21_to_23", 32'(r0 >= 21 && r0 <= 23), 32'd1);
    check("rst1_after_rst0", 32'(r1 - r0), 32'd4);
    check("ready_after_rst1", 32'(rdy - r1), 32'd1);

    // Lock glitch while qualifying: release slips by a full window, no loss counted.
    rst_n = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (13) tick();
    pll_lock = 1'b0;
    repeat (3) tick();
    pll_lock = 1'b1;
    r0g = -1;
    for (int n = 17; n <= 90; n++) begin
      tick();
      if (r0g < 0 && ch_rst_n[0]) r0g = n;
    end
    check("glitch_delays_release", 32'(r0g >= r0 + 16), 32'd1);
    check("glitch_no_loss", 32'(lock_loss_cnt), 32'd0);
    wait_ready(40);

    // Fractional enables over one full accumulator period.
    ch_inc    = {8'hC0, 8'h40};
    ch_en_req = 2'b11;
    last_ce0  = -1;
    for (int i = 0; i < NUM_CH; i++) pulses[i] = 0;
    win_left  = 256;
    repeat (256) tick();
    check("ce0_pulses", 32'(pulses[0]), 32'd64);
    check("ce1_pulses", 32'(pulses[1]), 32'd192);

    // Enable hold: park channel 0 at phase 0x40, then resume with inc 0x80.
    ch_en_req = 2'b01;
    ch_inc    = {8'hC0, 8'h40};
    tick();
    ch_inc[7:0]  = 8'h80;
    ch_en_req[0] = 1'b0;
    for (int n = 0; n < 10; n++) begin
      tick();
      check("hold_ce0", 32'(ch_ce[0]), 32'd0);
    end
    ch_en_req[0] = 1'b1;
    tick();
    check("resume_ce0_first", 32'(ch_ce[0]), 32'd0);
    tick();
    check("resume_ce0_second", 32'(ch_ce[0]), 32'd1);

    // Single-cycle lock loss in RUN.
    ch_inc    = {8'hFF, 8'h81};
    ch_en_req = 2'b11;
    pll_lock  = 1'b0;
    tick();
    pll_lock  = 1'b1;
    repeat (2) tick();
    check("loss_rst_n_low", 32'(ch_rst_n), 32'd0);
    check("loss_ce_low", 32'(ch_ce), 32'd0);
    check("loss_count_one", 32'(lock_loss_cnt), 32'd1);
    wait_ready(40);
    check("rerelease_rst_n", 32'(ch_rst_n), 32'd3);

    // Repeated drops drive the loss counter into saturation.
    for (int k = 0; k < 300; k++) begin
      ch_inc    = 16'($urandom());
      ch_en_req = 2'($urandom());
      pll_lock  = 1'b0;
      tick();
      pll_lock  = 1'b1;
      repeat (32) tick();
    end
    check("loss_saturated", 32'(lock_loss_cnt), 32'd255);

    // Asynchronous reset mid-operation clears outputs before any edge.
    #2 rst_n = 1'b0;
    #1;
    check("async_ce", 32'(ch_ce), 32'd0);
    check("async_rst_n", 32'(ch_rst_n), 32'd0);
    check("async_ready", 32'(all_ready), 32'd0);
    check("async_loss", 32'(lock_loss_cnt), 32'd0);
    check("async_pll_reset", 32'(pll_reset), 32'd0);
    repeat (3) tick();
    rst_n = 1'b1;

    // Randomised traffic with occasional lock drops once running.
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 7) == 0) ch_inc = 16'($urandom());
      ch_en_req = 2'($urandom());
      pll_lock  = (run_len > 30 && $urandom_range(0, 39) == 0) ? 1'b0 : 1'b1;
      tick();
    end
    pll_lock = 1'b1;
    repeat (4) tick();

`ifdef PLL_TIMEOUT_EN
    begin
      int rises[$];
      int high_n = 0;
      int rst_seen = 0;
      bit prev = 1'b0;
      sb_on    = 1'b0;
      tick();
      rst_n    = 1'b0;
      pll_lock = 1'b0;
      repeat (2) tick();
      rst_n = 1'b1;
      for (int n = 1; n <= 330; n++) begin
        tick();
        if (pll_reset && !prev) rises.push_back(n);
        if (pll_reset) high_n++;
        if (ch_rst_n != '0) rst_seen++;
        prev = pll_reset;
      end
      check("timeout_pulses", 32'(rises.size()), 32'd3);
      if (rises.size() == 3) begin
        check("timeout_first", 32'(rises[0]), 32'd100);
        check("timeout_period_a", 32'(rises[1] - rises[0]), 32'd108);
        check("timeout_period_b", 32'(rises[2] - rises[1]), 32'd108);
      end
      check("timeout_width", 32'(high_n), 32'd24);
      check("timeout_rst_n_low", 32'(rst_seen), 32'd0);
    end
`endif

    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
